// File: rtl/hazard_scoreboard.sv
// Stall controller for the pipelined MIPS core: E..W writer scoreboard, mult/div busy counter, EPC-before-eret interlock.
// Define HAZARD_STATS_EN to add the stall_cnt / md_stall_cnt statistics outputs.
module hazard_scoreboard #(
  parameter int STAGES      = 3,
  parameter int REG_AW      = 5,
  parameter int T_W         = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [T_W-1:0]    d_rs_tuse,
  input  logic [T_W-1:0]    d_rt_tuse,
  input  logic              d_we,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [T_W-1:0]    d_tnew,
  input  logic              d_md,
  input  logic              d_md_start,
  input  logic              d_md_is_div,
  input  logic              d_epc_wr,
  input  logic              d_eret,
  output logic              stall,
  output logic              md_busy,
  output logic [3:0]        md_left
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       md_stall_cnt
`endif
);

  localparam logic [T_W-1:0] TUSE_NONE = '1;
  localparam logic [T_W-1:0] T_ONE     = T_W'(1);
  localparam logic [3:0]     MULT_LD   = 4'(MULT_CYCLES);
  localparam logic [3:0]     DIV_LD    = 4'(DIV_CYCLES);

  function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_ONE;
  endfunction

  logic [STAGES-1:0] sb_vld;
  logic              sb_we   [STAGES];
  logic [REG_AW-1:0] sb_dst  [STAGES];
  logic [T_W-1:0]    sb_tnew [STAGES];
  logic              sb_epc  [STAGES];

  logic rs_hit, rt_hit, epc_hit;
  logic data_stall, md_stall, epc_stall, accept;

  // D-stage hazard detection against the scoreboard
  always_comb begin
    rs_hit  = 1'b0;
    rt_hit  = 1'b0;
    epc_hit = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      if (sb_vld[i] && sb_we[i] && (sb_dst[i] == d_rs) && (d_rs != '0) &&
          (d_rs_tuse != TUSE_NONE) && (sb_tnew[i] > d_rs_tuse))
        rs_hit = 1'b1;
      if (sb_vld[i] && sb_we[i] && (sb_dst[i] == d_rt) && (d_rt != '0) &&
          (d_rt_tuse != TUSE_NONE) && (sb_tnew[i] > d_rt_tuse))
        rt_hit = 1'b1;
      if (sb_vld[i] && sb_epc[i])
        epc_hit = 1'b1;
    end
  end

  assign data_stall = d_valid && (rs_hit || rt_hit);
  assign md_stall   = d_valid && d_md && md_busy;
  assign epc_stall  = d_valid && d_eret && epc_hit;
  assign stall      = data_stall || md_stall || epc_stall;
  assign accept     = d_valid && !stall;
  assign md_busy    = (md_left != '0);

  // Control state: entry valids and the mult/div countdown
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_vld  <= '0;
      md_left <= '0;
    end else begin
      for (int i = STAGES - 1; i > 0; i--)
        sb_vld[i] <= sb_vld[i-1] && !flush;
      sb_vld[0] <= accept && !flush;
      if (accept && d_md_start)
        md_left <= d_md_is_div ? DIV_LD : MULT_LD;
      else if (md_left != '0)
        md_left <= md_left - 4'd1;
    end
  end

  // Entry payload; only meaningful where the matching valid bit is set
  always_ff @(posedge clk) begin
    sb_we[0]   <= d_we;
    sb_dst[0]  <= d_dst;
    sb_tnew[0] <= d_tnew;
    sb_epc[0]  <= d_epc_wr;
    for (int i = 1; i < STAGES; i++) begin
      sb_we[i]   <= sb_we[i-1];
      sb_dst[i]  <= sb_dst[i-1];
      sb_tnew[i] <= tnew_dec(sb_tnew[i-1]);
      sb_epc[i]  <= sb_epc[i-1];
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall)
        stall_cnt <= stall_cnt + 32'd1;
      if (md_stall)
        md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: per-cycle vector table plus flush and reset-mid-divide sequences.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset, flush, d_valid;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_we, d_md, d_md_start, d_md_is_div, d_epc_wr, d_eret;
  logic       stall, md_busy;
  logic [3:0] md_left;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_we(d_we), .d_dst(d_dst), .d_tnew(d_tnew), .d_md(d_md),
    .d_md_start(d_md_start), .d_md_is_div(d_md_is_div), .d_epc_wr(d_epc_wr),
    .d_eret(d_eret), .stall(stall), .md_busy(md_busy), .md_left(md_left)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

  typedef struct {
    logic       rst, fl, vld;
    logic [4:0] rs, rt;
    logic [1:0] rs_tu, rt_tu;
    logic       we;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       md, mds, mdiv, epc, eret;
    logic       x_stall;
    logic       x_busy;
    logic [3:0] x_left;
  } vec_t;

  typedef struct {
    logic       stall, busy;
    logic [3:0] left;
    int         idx;
  } exp_t;

  vec_t tbl[$];
  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  function automatic vec_t nop();
    vec_t v;
    v = '{default: 0};
    v.rs_tu = 2'b11;
    v.rt_tu = 2'b11;
    return v;
  endfunction

  function automatic vec_t lw(input logic [4:0] dst);
    vec_t v = nop();
    v.vld = 1; v.rs = 5'd0; v.rs_tu = 2'd1; v.we = 1; v.dst = dst; v.tnew = 2'd2;
    return v;
  endfunction

  function automatic vec_t alu(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
    vec_t v = nop();
    v.vld = 1; v.rs = rs; v.rt = rt; v.rs_tu = 2'd1; v.rt_tu = 2'd1;
    v.we = 1; v.dst = dst; v.tnew = 2'd1;
    return v;
  endfunction

  function automatic vec_t beq(input logic [4:0] rs, input logic [4:0] rt);
    vec_t v = nop();
    v.vld = 1; v.rs = rs; v.rt = rt; v.rs_tu = 2'd0; v.rt_tu = 2'd0;
    return v;
  endfunction

  function automatic vec_t mdop(input logic is_div);
    vec_t v = nop();
    v.vld = 1; v.rs = 5'd4; v.rt = 5'd5; v.rs_tu = 2'd0; v.rt_tu = 2'd0;
    v.md = 1; v.mds = 1; v.mdiv = is_div;
    return v;
  endfunction

  function automatic vec_t mflo(input logic [4:0] dst);
    vec_t v = nop();
    v.vld = 1; v.md = 1; v.we = 1; v.dst = dst; v.tnew = 2'd1;
    return v;
  endfunction

  function automatic vec_t mtc0_epc();
    vec_t v = nop();
    v.vld = 1; v.rt = 5'd7; v.rt_tu = 2'd2; v.epc = 1;
    return v;
  endfunction

  function automatic vec_t eret();
    vec_t v = nop();
    v.vld = 1; v.eret = 1;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t v, input logic s, input logic b, input logic [3:0] l);
    vec_t r = v;
    r.x_stall = s; r.x_busy = b; r.x_left = l;
    return r;
  endfunction

  task automatic check_out();
    exp_t e;
    e = q.pop_front();
    n_cmp++;
    if (stall !== e.stall) begin
      n_bad++;
      $display("FAIL stall step %0d: got %b want %b", e.idx, stall, e.stall);
    end
    n_cmp++;
    if (md_busy !== e.busy) begin
      n_bad++;
      $display("FAIL md_busy step %0d: got %b want %b", e.idx, md_busy, e.busy);
    end
    n_cmp++;
    if (md_left !== e.left) begin
      n_bad++;
      $display("FAIL md_left step %0d: got %0d want %0d", e.idx, md_left, e.left);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    reset = v.rst; flush = v.fl; d_valid = v.vld;
    d_rs = v.rs; d_rt = v.rt; d_rs_tuse = v.rs_tu; d_rt_tuse = v.rt_tu;
    d_we = v.we; d_dst = v.dst; d_tnew = v.tnew;
    d_md = v.md; d_md_start = v.mds; d_md_is_div = v.mdiv;
    d_epc_wr = v.epc; d_eret = v.eret;
    e.stall = v.x_stall; e.busy = v.x_busy; e.left = v.x_left; e.idx = step_no;
    q.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
    step_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t v, r;
    // lw -> dependent add, lw -> beq, lw $0 -> beq $0
    tbl.push_back(ex(nop(), 0, 0, 0));
    tbl.push_back(ex(lw(5'd2), 0, 0, 0));
    tbl.push_back(ex(alu(5'd3, 5'd2, 5'd1), 1, 0, 0));
    tbl.push_back(ex(alu(5'd3, 5'd2, 5'd1), 0, 0, 0));
    tbl.push_back(ex(nop(), 0, 0, 0));
    tbl.push_back(ex(lw(5'd2), 0, 0, 0));
    tbl.push_back(ex(beq(5'd2, 5'd0), 1, 0, 0));
    tbl.push_back(ex(beq(5'd2, 5'd0), 1, 0, 0));
    tbl.push_back(ex(beq(5'd2, 5'd0), 0, 0, 0));
    tbl.push_back(ex(lw(5'd0), 0, 0, 0));
    tbl.push_back(ex(beq(5'd0, 5'd0), 0, 0, 0));
    tbl.push_back(ex(nop(), 0, 0, 0));
    // div then mflo: ten stalled cycles
    tbl.push_back(ex(mdop(1'b1), 0, 0, 0));
    for (int k = 10; k >= 1; k--)
      tbl.push_back(ex(mflo(5'd6), 1, 1, 4'(k)));
    tbl.push_back(ex(mflo(5'd6), 0, 0, 0));
    tbl.push_back(ex(nop(), 0, 0, 0));
    // mult countdown from five
    tbl.push_back(ex(mdop(1'b0), 0, 0, 0));
    for (int k = 5; k >= 1; k--)
      tbl.push_back(ex(nop(), 0, 1, 4'(k)));
    tbl.push_back(ex(nop(), 0, 0, 0));
    // mtc0 EPC then eret
    tbl.push_back(ex(mtc0_epc(), 0, 0, 0));
    tbl.push_back(ex(eret(), 1, 0, 0));
    tbl.push_back(ex(eret(), 1, 0, 0));
    tbl.push_back(ex(eret(), 1, 0, 0));
    tbl.push_back(ex(eret(), 0, 0, 0));
    tbl.push_back(ex(nop(), 0, 0, 0));
    // rt-side hazard
    tbl.push_back(ex(lw(5'd9), 0, 0, 0));
    tbl.push_back(ex(alu(5'd11, 5'd1, 5'd9), 1, 0, 0));
    tbl.push_back(ex(alu(5'd11, 5'd1, 5'd9), 0, 0, 0));
    // bubble in D never stalls; tnew ages as the writer moves down
    tbl.push_back(ex(lw(5'd10), 0, 0, 0));
    v = beq(5'd10, 5'd0); v.vld = 0;
    tbl.push_back(ex(v, 0, 0, 0));
    tbl.push_back(ex(beq(5'd10, 5'd0), 1, 0, 0));
    tbl.push_back(ex(beq(5'd10, 5'd0), 0, 0, 0));

    reset = 1; flush = 0; d_valid = 0; d_rs = 0; d_rt = 0; d_rs_tuse = 2'b11; d_rt_tuse = 2'b11;
    d_we = 0; d_dst = 0; d_tnew = 0; d_md = 0; d_md_start = 0; d_md_is_div = 0;
    d_epc_wr = 0; d_eret = 0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i]);

    // flush kills lw $2 in E; mult countdown continues through it
    step(ex(mdop(1'b0), 0, 0, 0));
    step(ex(lw(5'd2), 0, 1, 4'd5));
    v = nop(); v.fl = 1;
    step(ex(v, 0, 1, 4'd4));
    step(ex(beq(5'd2, 5'd0), 0, 1, 4'd3));
    step(ex(nop(), 0, 1, 4'd2));
    step(ex(nop(), 0, 1, 4'd1));
    step(ex(nop(), 0, 0, 4'd0));

    // reset while md_left=6 with mtc0 and lw in flight
    step(ex(mdop(1'b1), 0, 0, 0));
    step(ex(nop(), 0, 1, 4'd10));
    step(ex(nop(), 0, 1, 4'd9));
    step(ex(mtc0_epc(), 0, 1, 4'd8));
    step(ex(lw(5'd2), 0, 1, 4'd7));
    r = nop(); r.rst = 1;
    step(ex(r, 0, 1, 4'd6));
    step(ex(eret(), 0, 0, 4'd0));
    step(ex(mflo(5'd6), 0, 0, 4'd0));
    step(ex(beq(5'd2, 5'd2), 0, 0, 4'd0));

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised stall controller for the pipelined MIPS core. Sits beside the D-stage control unit.
- Consumes the decoded Tuse/Tnew/destination information of the instruction in D. Tracks every in-flight writer in a shift-register scoreboard covering E..W.
- Owns the multiply/divide busy counter and the EPC write-before-eret interlock. Drives the single stall signal that freezes PC/F/D and injects a bubble into E.

Parameters:
- STAGES, 3, number of tracked stages after D (E, M, W); entry 0 = E.
- REG_AW, 5, register address width.
- T_W, 2, Tuse/Tnew width; all-ones Tuse means "operand not used".
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  exception/eret flush; kills all in-flight entries
- d_valid  in  1  D holds a real instruction (0 = bubble)
- d_rs  in  REG_AW  rs address of D instruction
- d_rt  in  REG_AW  rt address of D instruction
- d_rs_tuse  in  T_W  cycles until rs is needed; all-ones = unused
- d_rt_tuse  in  T_W  cycles until rt is needed; all-ones = unused
- d_we  in  1  D instruction writes the GPR file
- d_dst  in  REG_AW  destination register
- d_tnew  in  T_W  cycles after entering E until the result is forwardable
- d_md  in  1  any mult/div/mfhi/mflo/mthi/mtlo
- d_md_start  in  1  mult/multu/div/divu
- d_md_is_div  in  1  qualifies d_md_start: 1 = div/divu
- d_epc_wr  in  1  mtc0 targeting EPC (CP0 reg 14)
- d_eret  in  1  eret in D
- stall  out  1  freeze F/D, bubble into E
- md_busy  out  1  multiply/divide unit busy
- md_left  out  4  remaining busy cycles

Behaviour:
- Reset: all entries invalid, md counter 0, epc_pend 0. stall=0, md_busy=0, md_left=0.
- Entry fields: valid, we, dst, tnew, epc.
- Per-clock update, with flush=0:
  - entry[i+1] <= entry[i], tnew decremented and saturating at 0.
  - entry[0] <= D fields if d_valid && !stall, otherwise a bubble (valid=0).
  - The entry shifted past index STAGES-1 is dropped.
- Data stall, rs: some valid, we entry i has dst==d_rs, d_rs!=0, tuse!=all-ones, and entry[i].tnew > d_rs_tuse. Same rule for rt.
  - Comparison uses current stored tnew, which is already relative to the entry's stage.
- MD stall: d_valid && d_md && md_busy.
- md_busy = (md_left != 0).
  - md_left loads MULT_CYCLES or DIV_CYCLES on an accepted d_md_start (d_valid && !stall).
  - Otherwise decrements to 0.
  - A load in the same cycle as the last decrement wins.
- EPC stall: d_valid && d_eret && any valid entry has epc=1.
- stall = OR of data, MD and EPC stall. Purely combinational from D inputs and registered state; same-cycle.
- stall is forced 0 when d_valid=0.
- flush=1: all entries invalidated next edge, and the D instruction is not inserted. md_left keeps counting; an issued mult/div always completes.
- reset has priority over flush. Reset mid-md clears md_left immediately.
- Width rules:
  - Tnew decrement never wraps.
  - dst==0 entries never cause a stall.
  - MULT_CYCLES/DIV_CYCLES must fit in 4 bits; the loaded value is truncated to md_left width.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds outputs stall_cnt (32) and md_stall_cnt (32).
  - stall_cnt counts cycles with stall=1; md_stall_cnt counts cycles with MD stall.
  - Both reset to 0 and wrap at 2^32.
- When undefined, these ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- lw $2 (d_tnew=2), then next cycle add $3,$2,$1 (rs_tuse=1) -> stall=1 for exactly 1 cycle, then add accepted.
- lw $2, then beq $2,$0 (rs_tuse=0) -> stall=1 for 2 cycles; lw to $0 followed by beq $0 -> stall=0.
- div accepted (DIV_CYCLES=10), then mflo on the next cycle -> md_busy=1 and stall=1 for 10 cycles; mflo accepted when md_left reaches 0.
- mtc0 EPC issued, eret next cycle -> stall held until the mtc0 entry leaves W (3 cycles with STAGES=3); then eret accepted.
- lw $2 in E plus flush=1, then add $3,$2,$1 -> no stall after flush; md_left unaffected by flush.
- reset asserted while md_left=6 and entries valid -> next cycle md_left=0, stall=0, all entries invalid.
